// File: rtl/arb_request_mux.sv
// ============================================================================
// Module : arb_request_mux
// Brief  : Registered N:1 request mux around a round-robin arbiter; one slot.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_request_mux #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            arb_req_o,
  output logic                          arb_allow_o,
  input  logic [NUM_REQ-1:0]            arb_gnt_i,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [IDX_W-1:0]              out_index_o,
  input  logic                          out_ready_i,
  output logic                          grant_err_o
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e             r_state;
  slot_state_e             w_state_next;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [IDX_W-1:0]        r_index;
  logic                    r_grant_err;

  logic                    w_slot_free;
  logic [NUM_REQ-1:0]      w_eff_gnt;
  logic                    w_gnt_any;
  logic                    w_gnt_multi;
  logic                    w_illegal;
  logic                    w_accept;
  logic [IDX_W-1:0]        w_gnt_idx;
  logic [DATA_WIDTH-1:0]   w_gnt_data;

  assign w_slot_free = (r_state == EMPTY) | out_ready_i;
  assign arb_allow_o = w_slot_free;
  assign arb_req_o   = req_valid_i;

  // x & (x-1) clears the lowest set bit; nonzero remainder means >1 bit set.
  assign w_eff_gnt   = arb_gnt_i & req_valid_i;
  assign w_gnt_any   = |arb_gnt_i;
  assign w_gnt_multi = |(arb_gnt_i & (arb_gnt_i - NUM_REQ'(1)));
  assign w_illegal   = w_gnt_multi | (arb_gnt_i != w_eff_gnt) | (w_gnt_any & ~w_slot_free);
  assign w_accept    = w_slot_free & w_gnt_any & ~w_illegal;

  // Grant is one-hot whenever it is used, so an OR-reduction mux suffices.
  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_eff_gnt[k]) begin
        w_gnt_idx = IDX_W'(k);
      end
      w_gnt_data = w_gnt_data |
                   (req_data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_eff_gnt[k]}});
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = '0;
    if (w_accept && rst_ni) begin
      req_ready_o = w_eff_gnt;
    end
    case (r_state)
      EMPTY:   if (w_accept) w_state_next = FULL;
      FULL:    if (!w_accept && out_ready_i) w_state_next = EMPTY;
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= EMPTY;
      r_data      <= '0;
      r_index     <= '0;
      r_grant_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_grant_err <= w_illegal;
      if (w_accept) begin
        r_data  <= w_gnt_data;
        r_index <= w_gnt_idx;
      end
    end
  end

  assign out_valid_o = (r_state == FULL);
  assign out_data_o  = r_data;
  assign out_index_o = r_index;
  assign grant_err_o = r_grant_err;

endmodule

`default_nettype wire
